// File: rtl/fx3_slave_fifo_writer.sv
// rtl/fx3_slave_fifo_writer.sv - buffers a 32-bit pixel stream and writes it to the FX3 synchronous slave FIFO
module fx3_slave_fifo_writer #(
   parameter int FIFO_DEPTH   = 512,
   parameter int BURST_WORDS  = 1024,
   parameter int FLAG_LATENCY = 3
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic [31:0]                   data_i,
   input  logic                          data_valid_i,
   input  logic                          frame_end_i,
   input  logic                          fx3_full_n_i,
   output logic [31:0]                   fx3_data_o,
   output logic                          fx3_slwr_n_o,
   output logic                          fx3_pktend_n_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          overflow_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(BURST_WORDS + 1);
   localparam int WW = (FLAG_LATENCY > 0) ? $clog2(FLAG_LATENCY + 1) : 1;

   typedef enum logic [1:0] {IDLE, BURST, PKTEND, WAIT_FLAG} state_t;

   state_t         state, state_n;
   logic [31:0]    mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [LW-1:0]  level;
   logic [CW-1:0]  buf_cnt;
   logic [WW-1:0]  wait_cnt;
   logic           pending;
   logic           empty, full, push, pop, drop;
   logic           pending_clr, cnt_clr;

   assign empty        = (level == '0);
   assign full         = (level == LW'(FIFO_DEPTH));
   assign pop          = (state == BURST) && !empty && fx3_full_n_i && (buf_cnt < CW'(BURST_WORDS));
   // a full FIFO still accepts a word when one leaves in the same cycle
   assign push         = data_valid_i && (!full || pop);
   assign drop         = data_valid_i && full && !pop;
   assign fifo_level_o = level;

   always_comb begin
      state_n     = state;
      pending_clr = 1'b0;
      cnt_clr     = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && fx3_full_n_i) begin
               state_n = BURST;
            end else if (pending && empty) begin
               if (buf_cnt != '0) state_n = PKTEND;
               else               pending_clr = 1'b1;
            end
         end
         BURST: begin
            if (pop) begin
               if (buf_cnt == CW'(BURST_WORDS - 1)) begin
                  state_n = WAIT_FLAG;
                  cnt_clr = 1'b1;
               end else if (level == LW'(1) && !push) begin
                  state_n = IDLE;
               end
            end else if (empty) begin
               state_n = IDLE;
            end
         end
         PKTEND: begin
            pending_clr = 1'b1;
            cnt_clr     = 1'b1;
            state_n     = WAIT_FLAG;
         end
         WAIT_FLAG: begin
            if (wait_cnt == WW'(FLAG_LATENCY)) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= data_i;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state          <= IDLE;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level          <= '0;
         buf_cnt        <= '0;
         wait_cnt       <= '0;
         pending        <= 1'b0;
         overflow_o     <= 1'b0;
         fx3_data_o     <= '0;
         fx3_slwr_n_o   <= 1'b1;
         fx3_pktend_n_o <= 1'b1;
      end else begin
         state <= state_n;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (cnt_clr)  buf_cnt <= '0;
         else if (pop) buf_cnt <= buf_cnt + CW'(1);
         wait_cnt <= (state == WAIT_FLAG) ? wait_cnt + WW'(1) : '0;
         // a new frame end wins over a clear in the same cycle
         if (frame_end_i)      pending <= 1'b1;
         else if (pending_clr) pending <= 1'b0;
         if (drop) overflow_o <= 1'b1;
         if (pop)  fx3_data_o <= mem[rd_ptr];
         fx3_slwr_n_o   <= !pop;
         fx3_pktend_n_o <= !(state_n == PKTEND);
      end
   end
endmodule
